// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the PC fetch controller: FSM state encodings and instruction size.
package pc_ctrl_pkg;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned BOOT_CNT_W  = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: boot > pending > jump > branch > hold > sequential,
// followed by the instruction-memory wrap compare.
module pc_next_sel
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter logic [ADDR_W-1:0]   IMEM_LAST = ADDR_W'(248)
) (
  input  logic              sel_boot,
  input  logic              sel_pend,
  input  logic              sel_jump,
  input  logic              sel_branch,
  input  logic              sel_hold,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pending_pc,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] new_pc
);

  logic [ADDR_W-1:0] raw_pc;

  always_comb begin
    if (sel_boot)        raw_pc = RESET_PC;
    else if (sel_pend)   raw_pc = pending_pc;
    else if (sel_jump)   raw_pc = jump_target;
    else if (sel_branch) raw_pc = branch_target;
    else if (sel_hold)   raw_pc = pc;
    else                 raw_pc = pc + ADDR_W'(INSTR_BYTES);
    // Anything past the last fetchable word, redirects included, restarts at RESET_PC.
    new_pc = (raw_pc > IMEM_LAST) ? RESET_PC : raw_pc;
  end

endmodule

// File: rtl/pc_fetch_controller.sv
// PC sequencing FSM (BOOT/RUN/STALL/HALT) with boot hold counter and redirect handling.
// Define PC_DELAY_SLOT_EN to defer redirects by one instruction (branch delay slot).
module pc_fetch_controller
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned         ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
  parameter logic [ADDR_W-1:0]   IMEM_LAST   = ADDR_W'(248),
  parameter int unsigned         BOOT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              Stall,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              Halt,
  output logic [ADDR_W-1:0] NewPC,
  output logic              WriteEnable,
  output logic              FlushIFID,
  output logic              Halted
);

  logic [1:0]            state_q, state_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic                  sel_boot, sel_pend, sel_jump, sel_branch, sel_hold;
  logic [ADDR_W-1:0]     pend_pc_sel;

`ifdef PC_DELAY_SLOT_EN
  logic                  pending_valid_q, pending_valid_d;
  logic [ADDR_W-1:0]     pending_pc_q, pending_pc_d;
  assign pend_pc_sel = pending_pc_q;
`else
  assign pend_pc_sel = '0;
`endif

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    sel_boot    = 1'b0;
    sel_pend    = 1'b0;
    sel_jump    = 1'b0;
    sel_branch  = 1'b0;
    sel_hold    = 1'b1;
    WriteEnable = 1'b0;
    FlushIFID   = 1'b0;
`ifdef PC_DELAY_SLOT_EN
    pending_valid_d = pending_valid_q;
    pending_pc_d    = pending_pc_q;
`endif
    case (state_q)
      BOOT: begin
        sel_boot = 1'b1;
        if (boot_cnt_q != '0) boot_cnt_d = boot_cnt_q - 1'b1;
        if (boot_cnt_q <= BOOT_CNT_W'(1)) state_d = RUN;
      end
      RUN, STALL: begin
`ifdef PC_DELAY_SLOT_EN
        if (Halt) begin
          state_d         = HALT;
          pending_valid_d = 1'b0;
        end else if (Stall) begin
          // A redirect under stall is still captured; the stall update happens meanwhile.
          state_d = STALL;
          if (!pending_valid_q && (Jump || BranchTaken)) begin
            pending_valid_d = 1'b1;
            pending_pc_d    = Jump ? JumpTarget : BranchTarget;
          end
        end else begin
          state_d     = RUN;
          sel_hold    = 1'b0;
          WriteEnable = 1'b1;
          if (pending_valid_q) begin
            sel_pend        = 1'b1;
            pending_valid_d = 1'b0;
          end else if (Jump || BranchTaken) begin
            pending_valid_d = 1'b1;
            pending_pc_d    = Jump ? JumpTarget : BranchTarget;
          end
        end
`else
        if (Halt) begin
          state_d = HALT;
        end else if (Jump || BranchTaken) begin
          state_d     = RUN;
          sel_jump    = Jump;
          sel_branch  = BranchTaken;
          sel_hold    = 1'b0;
          WriteEnable = 1'b1;
          FlushIFID   = 1'b1;
        end else if (Stall) begin
          state_d = STALL;
        end else begin
          state_d     = RUN;
          sel_hold    = 1'b0;
          WriteEnable = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  assign Halted = (state_q == HALT);

  pc_next_sel #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .IMEM_LAST(IMEM_LAST)
  ) u_next_sel (
    .sel_boot     (sel_boot),
    .sel_pend     (sel_pend),
    .sel_jump     (sel_jump),
    .sel_branch   (sel_branch),
    .sel_hold     (sel_hold),
    .pc           (PC),
    .pending_pc   (pend_pc_sel),
    .jump_target  (JumpTarget),
    .branch_target(BranchTarget),
    .new_pc       (NewPC)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= BOOT;
      boot_cnt_q <= BOOT_CNT_W'(BOOT_CYCLES);
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

`ifdef PC_DELAY_SLOT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pending_valid_q <= 1'b0;
      pending_pc_q    <= '0;
    end else begin
      pending_valid_q <= pending_valid_d;
      pending_pc_q    <= pending_pc_d;
    end
  end
`endif

endmodule
